lcd_frame_capture: RTL and testbench

- Sink end of the PPU LCD output stream.
- Consumes 2-bit pixels strobed by pixel_latch and framed by hsync/vsync.
- Packs pixels four per byte and writes them into a double-buffered 160x144 2bpp framebuffer.
- Swaps banks on each complete frame, so the scan-out/VGA side always reads a whole, stable frame.

---
 rtl/lcd_frame_capture.sv | 219 +++++++++++++++++++++
 tb/tb_lcd_frame_capture.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_frame_capture.sv
// Sink for the PPU LCD pixel stream: packs 2bpp pixels four per byte into a
// double-buffered framebuffer and swaps banks on every cleanly completed frame.
module lcd_frame_capture #(
    parameter int H_PIXELS = 160,
    parameter int V_LINES  = 144,
    parameter int OFFSET_W = 13
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                capture_en,
    input  logic                hsync,
    input  logic                vsync,
    input  logic [1:0]          pixel_data,
    input  logic                pixel_latch,
    input  logic                clear_errors,
    output logic [OFFSET_W:0]   fb_addr,
    output logic [7:0]          fb_data,
    output logic                fb_we,
    output logic                front_bank,
    output logic                frame_done,
    output logic                line_error,
    output logic                overrun_error,
    output logic                frame_error
);

    localparam int X_W = $clog2(H_PIXELS + 1);
    localparam int Y_W = $clog2(V_LINES + 1);
    localparam logic [X_W-1:0]      X_MAX          = X_W'(H_PIXELS);
    localparam logic [Y_W-1:0]      Y_MAX          = Y_W'(V_LINES);
    localparam logic [X_W-1:0]      X_ONE          = X_W'(1);
    localparam logic [Y_W-1:0]      Y_ONE          = Y_W'(1);
    localparam logic [OFFSET_W-1:0] BYTES_PER_LINE = OFFSET_W'(H_PIXELS / 4);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SYNC_WAIT = 2'd1,
        CAPTURE   = 2'd2
    } state_t;

    // Left-justifies a partially filled packer so missing trailing pixels read as 0.
    function automatic logic [7:0] align_byte(input logic [7:0] s, input logic [1:0] n);
        logic [7:0] r;
        case (n)
            2'd1:    r = {s[1:0], 6'd0};
            2'd2:    r = {s[3:0], 4'd0};
            2'd3:    r = {s[5:0], 2'd0};
            default: r = s;
        endcase
        return r;
    endfunction

    state_t                state_q, state_d;
    logic [X_W-1:0]        x_q, x_d, x_acc, x_line, x_m1;
    logic [Y_W-1:0]        y_q, y_d, y_line;
    logic [7:0]            shift_q, shift_d, shift_acc, shift_line;
    logic                  hsync_q, vsync_q;
    logic                  h_edge, v_edge;
    logic                  emit, line_set, ovr_set, frm_set;
    logic [OFFSET_W-1:0]   offset;
    logic [OFFSET_W:0]     fb_addr_q, fb_addr_d;
    logic [7:0]            fb_data_q, fb_data_d;
    logic                  fb_we_q, fb_we_d;
    logic                  front_bank_q, front_bank_d;
    logic                  frame_done_q, frame_done_d;
    logic                  line_error_q, line_error_d;
    logic                  overrun_error_q, overrun_error_d;
    logic                  frame_error_q, frame_error_d;

    assign h_edge = hsync & ~hsync_q;
    assign v_edge = vsync & ~vsync_q;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; dropping capture_en abandons any frame in progress.
    always_comb begin
        state_d = state_q;
        if (!capture_en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:      state_d = SYNC_WAIT;
                SYNC_WAIT: state_d = v_edge ? CAPTURE : SYNC_WAIT;
                CAPTURE:   state_d = CAPTURE;
                default:   state_d = IDLE;
            endcase
        end
    end

    // Datapath: pixel accept, then line end, then frame end, all in one cycle.
    always_comb begin
        x_acc        = x_q;
        shift_acc    = shift_q;
        x_line       = x_q;
        y_line       = y_q;
        shift_line   = shift_q;
        emit         = 1'b0;
        line_set     = 1'b0;
        ovr_set      = 1'b0;
        frm_set      = 1'b0;
        x_d          = x_q;
        y_d          = y_q;
        shift_d      = shift_q;
        front_bank_d = front_bank_q;
        frame_done_d = 1'b0;
        if (state_q == SYNC_WAIT && capture_en && v_edge) begin
            x_d     = {X_W{1'b0}};
            y_d     = {Y_W{1'b0}};
            shift_d = 8'd0;
        end else if (state_q == CAPTURE && capture_en) begin
            if (pixel_latch) begin
                if (x_q < X_MAX && y_q < Y_MAX) begin
                    x_acc     = x_q + X_ONE;
                    shift_acc = {shift_q[5:0], pixel_data};
                    emit      = (x_q[1:0] == 2'd3);
                end else begin
                    ovr_set = 1'b1;
                end
            end else begin
                emit = 1'b0;
            end
            x_line     = x_acc;
            shift_line = shift_acc;
            if (h_edge && x_acc != {X_W{1'b0}}) begin
                // A short line still commits its partial byte.
                if (x_acc < X_MAX) begin
                    line_set = 1'b1;
                    emit     = emit | (x_acc[1:0] != 2'd0);
                end else begin
                    line_set = 1'b0;
                end
                x_line     = {X_W{1'b0}};
                shift_line = 8'd0;
                y_line     = (y_q < Y_MAX) ? (y_q + Y_ONE) : y_q;
            end else begin
                y_line = y_q;
            end
            if (v_edge) begin
                if (y_line == Y_MAX && x_line == {X_W{1'b0}}) begin
                    front_bank_d = ~front_bank_q;
                    frame_done_d = 1'b1;
                end else begin
                    frm_set = 1'b1;
                end
                x_line     = {X_W{1'b0}};
                y_line     = {Y_W{1'b0}};
                shift_line = 8'd0;
            end else begin
                frm_set = 1'b0;
            end
            x_d     = x_line;
            y_d     = y_line;
            shift_d = shift_line;
        end else begin
            emit = 1'b0;
        end
    end

    // Write port and sticky error flags; a same-cycle error beats clear_errors.
    always_comb begin
        x_m1            = x_acc - X_ONE;
        offset          = OFFSET_W'(y_q) * BYTES_PER_LINE + OFFSET_W'(x_m1 >> 2);
        fb_we_d         = emit;
        fb_addr_d       = emit ? {~front_bank_q, offset} : fb_addr_q;
        fb_data_d       = emit ? align_byte(shift_acc, x_acc[1:0]) : fb_data_q;
        line_error_d    = (line_error_q & ~clear_errors) | line_set;
        overrun_error_d = (overrun_error_q & ~clear_errors) | ovr_set;
        frame_error_d   = (frame_error_q & ~clear_errors) | frm_set;
    end

    // Datapath and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            x_q             <= {X_W{1'b0}};
            y_q             <= {Y_W{1'b0}};
            shift_q         <= 8'd0;
            hsync_q         <= 1'b0;
            vsync_q         <= 1'b0;
            fb_addr_q       <= {(OFFSET_W + 1){1'b0}};
            fb_data_q       <= 8'd0;
            fb_we_q         <= 1'b0;
            front_bank_q    <= 1'b0;
            frame_done_q    <= 1'b0;
            line_error_q    <= 1'b0;
            overrun_error_q <= 1'b0;
            frame_error_q   <= 1'b0;
        end else begin
            x_q             <= x_d;
            y_q             <= y_d;
            shift_q         <= shift_d;
            hsync_q         <= hsync;
            vsync_q         <= vsync;
            fb_addr_q       <= fb_addr_d;
            fb_data_q       <= fb_data_d;
            fb_we_q         <= fb_we_d;
            front_bank_q    <= front_bank_d;
            frame_done_q    <= frame_done_d;
            line_error_q    <= line_error_d;
            overrun_error_q <= overrun_error_d;
            frame_error_q   <= frame_error_d;
        end
    end

    assign fb_addr       = fb_addr_q;
    assign fb_data       = fb_data_q;
    assign fb_we         = fb_we_q;
    assign front_bank    = front_bank_q;
    assign frame_done    = frame_done_q;
    assign line_error    = line_error_q;
    assign overrun_error = overrun_error_q;
    assign frame_error   = frame_error_q;

endmodule

// File: tb/tb_lcd_frame_capture.sv
// Directed bench for lcd_frame_capture: each task drives one scenario and
// compares outputs against hand-computed values.
module tb_lcd_frame_capture;

    logic        clock = 1'b0;
    logic        reset, capture_en, hsync, vsync, pixel_latch, clear_errors;
    logic [1:0]  pixel_data;
    logic [13:0] fb_addr;
    logic [7:0]  fb_data;
    logic        fb_we, front_bank, frame_done, line_error, overrun_error, frame_error;

    int total = 0;
    int bad   = 0;

    lcd_frame_capture #(.H_PIXELS(160), .V_LINES(144), .OFFSET_W(13)) dut (
        .clock(clock), .reset(reset), .capture_en(capture_en), .hsync(hsync),
        .vsync(vsync), .pixel_data(pixel_data), .pixel_latch(pixel_latch),
        .clear_errors(clear_errors), .fb_addr(fb_addr), .fb_data(fb_data),
        .fb_we(fb_we), .front_bank(front_bank), .frame_done(frame_done),
        .line_error(line_error), .overrun_error(overrun_error), .frame_error(frame_error)
    );

    always #5 clock = ~clock;

    // Write/frame_done recorder, sampled on the falling edge.
    logic [7:0]  mem [0:16383];
    logic [13:0] q_addr [$];
    logic [7:0]  q_data [$];
    int          wr_count = 0;
    int          fd_count = 0;
    logic        mon_clr  = 1'b0;

    always @(negedge clock) begin
        if (mon_clr) begin
            wr_count = 0;
            fd_count = 0;
            q_addr.delete();
            q_data.delete();
            for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
        end
        if (fb_we) begin
            wr_count++;
            mem[fb_addr] = fb_data;
            q_addr.push_back(fb_addr);
            q_data.push_back(fb_data);
        end
        if (frame_done) fd_count++;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic mon_clear();
        mon_clr = 1'b1;
        tick();
        mon_clr = 1'b0;
    endtask

    task automatic send_pixels(input int n, input bit by_x, input logic [1:0] val);
        for (int i = 0; i < n; i++) begin
            pixel_latch = 1'b1;
            pixel_data  = by_x ? 2'(i % 4) : val;
            tick();
        end
        pixel_latch = 1'b0;
    endtask

    task automatic hpulse();
        hsync = 1'b1;
        tick();
        hsync = 1'b0;
        tick();
    endtask

    task automatic vpulse();
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        tick();
    endtask

    task automatic clear_pulse();
        clear_errors = 1'b1;
        tick();
        clear_errors = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; capture_en = 1'b0; hsync = 1'b0; vsync = 1'b0;
        pixel_latch = 1'b0; pixel_data = 2'd0; clear_errors = 1'b0;
        tick(); tick();
        reset = 1'b0;
        total++; if (fb_addr !== 14'h0000) begin bad++; $display("FAIL reset_fb_addr: got %0h want %0h", fb_addr, 14'h0000); end
        total++; if (fb_data !== 8'h00) begin bad++; $display("FAIL reset_fb_data: got %0h want %0h", fb_data, 8'h00); end
        total++; if (fb_we !== 1'b0) begin bad++; $display("FAIL reset_fb_we: got %0b want 0", fb_we); end
        total++; if (front_bank !== 1'b0) begin bad++; $display("FAIL reset_front_bank: got %0b want 0", front_bank); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done: got %0b want 0", frame_done); end
        total++; if ({line_error, overrun_error, frame_error} !== 3'b000) begin bad++; $display("FAIL reset_errors: got %0b want 000", {line_error, overrun_error, frame_error}); end
    endtask

    task automatic test_full_frame();
        int odd;
        logic [13:0] a_first, a_last;
        capture_en = 1'b1;
        tick();
        mon_clear();
        vpulse();
        for (int l = 0; l < 144; l++) begin
            send_pixels(160, 1'b1, 2'd0);
            hpulse();
        end
        vpulse();
        tick();
        odd = 0;
        for (int a = 14'h2000; a <= 14'h367F; a++) if (mem[a] !== 8'h1B) odd++;
        a_first = (q_addr.size() > 0) ? q_addr[0] : 14'h0000;
        a_last  = (q_addr.size() > 0) ? q_addr[$] : 14'h0000;
        total++; if (wr_count !== 5760) begin bad++; $display("FAIL full_wr_count: got %0d want 5760", wr_count); end
        total++; if (a_first !== 14'h2000) begin bad++; $display("FAIL full_first_addr: got %0h want 2000", a_first); end
        total++; if (a_last !== 14'h367F) begin bad++; $display("FAIL full_last_addr: got %0h want 367f", a_last); end
        total++; if (odd !== 0) begin bad++; $display("FAIL full_bytes: got %0d bytes not 1b want 0", odd); end
        total++; if (front_bank !== 1'b1) begin bad++; $display("FAIL full_front_bank: got %0b want 1", front_bank); end
        total++; if (fd_count !== 1) begin bad++; $display("FAIL full_frame_done: got %0d pulses want 1", fd_count); end
        total++; if ({line_error, overrun_error, frame_error} !== 3'b000) begin bad++; $display("FAIL full_errors: got %0b want 000", {line_error, overrun_error, frame_error}); end
    endtask

    task automatic test_short_line();
        logic [13:0] a0, a1, a2;
        logic [7:0]  d0, d1, d2;
        mon_clear();
        send_pixels(6, 1'b0, 2'd3);
        hpulse();
        send_pixels(4, 1'b1, 2'd0);
        tick();
        a0 = (q_addr.size() > 0) ? q_addr[0] : 14'h3FFF; d0 = (q_data.size() > 0) ? q_data[0] : 8'h00;
        a1 = (q_addr.size() > 1) ? q_addr[1] : 14'h3FFF; d1 = (q_data.size() > 1) ? q_data[1] : 8'h00;
        a2 = (q_addr.size() > 2) ? q_addr[2] : 14'h3FFF; d2 = (q_data.size() > 2) ? q_data[2] : 8'h00;
        total++; if (wr_count !== 3) begin bad++; $display("FAIL short_wr_count: got %0d want 3", wr_count); end
        total++; if (a0 !== 14'd0 || d0 !== 8'hFF) begin bad++; $display("FAIL short_byte0: got %0h/%0h want 0/ff", a0, d0); end
        total++; if (a1 !== 14'd1 || d1 !== 8'hF0) begin bad++; $display("FAIL short_flush: got %0h/%0h want 1/f0", a1, d1); end
        total++; if (line_error !== 1'b1) begin bad++; $display("FAIL short_line_error: got %0b want 1", line_error); end
        total++; if (a2 !== 14'd40 || d2 !== 8'h1B) begin bad++; $display("FAIL short_next_line: got %0h/%0h want 28/1b", a2, d2); end
    endtask

    task automatic test_reset_mid_line();
        send_pixels(4, 1'b1, 2'd0);
        total++; if (fb_we !== 1'b1 || fb_addr !== 14'd41) begin bad++; $display("FAIL rst_pre_write: got %0b/%0h want 1/29", fb_we, fb_addr); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if (fb_we !== 1'b0) begin bad++; $display("FAIL rst_fb_we: got %0b want 0", fb_we); end
        total++; if ({fb_addr, fb_data} !== 22'h0) begin bad++; $display("FAIL rst_addr_data: got %0h want 0", {fb_addr, fb_data}); end
        total++; if ({front_bank, frame_done, line_error, overrun_error, frame_error} !== 5'b00000) begin bad++; $display("FAIL rst_flags: got %0b want 00000", {front_bank, frame_done, line_error, overrun_error, frame_error}); end
        mon_clear();
        send_pixels(4, 1'b1, 2'd0);
        hpulse();
        tick();
        total++; if (wr_count !== 0) begin bad++; $display("FAIL rst_idle_no_write: got %0d want 0", wr_count); end
    endtask

    task automatic test_mid_enable();
        logic [13:0] a_first;
        capture_en = 1'b0;
        tick(); tick();
        capture_en = 1'b1;
        mon_clear();
        send_pixels(8, 1'b1, 2'd0);
        hpulse();
        send_pixels(8, 1'b1, 2'd0);
        hpulse();
        tick();
        total++; if (wr_count !== 0) begin bad++; $display("FAIL midena_no_write: got %0d want 0", wr_count); end
        vpulse();
        for (int l = 0; l < 143; l++) begin
            send_pixels(160, 1'b1, 2'd0);
            hpulse();
        end
        vpulse();
        tick();
        a_first = (q_addr.size() > 0) ? q_addr[0] : 14'h0000;
        total++; if (wr_count !== 5720) begin bad++; $display("FAIL midena_wr_count: got %0d want 5720", wr_count); end
        total++; if (a_first !== 14'h2000) begin bad++; $display("FAIL midena_first_addr: got %0h want 2000", a_first); end
        total++; if (frame_error !== 1'b1) begin bad++; $display("FAIL midena_frame_error: got %0b want 1", frame_error); end
        total++; if (fd_count !== 0) begin bad++; $display("FAIL midena_frame_done: got %0d want 0", fd_count); end
        total++; if (front_bank !== 1'b0) begin bad++; $display("FAIL midena_front_bank: got %0b want 0", front_bank); end
    endtask

    task automatic test_overrun();
        logic [13:0] a_last;
        clear_pulse();
        total++; if (frame_error !== 1'b0) begin bad++; $display("FAIL ovr_clear_frame: got %0b want 0", frame_error); end
        mon_clear();
        send_pixels(162, 1'b1, 2'd0);
        tick();
        a_last = (q_addr.size() > 0) ? q_addr[$] : 14'h0000;
        total++; if (wr_count !== 40) begin bad++; $display("FAIL ovr_wr_count: got %0d want 40", wr_count); end
        total++; if (a_last !== 14'h2027) begin bad++; $display("FAIL ovr_last_addr: got %0h want 2027", a_last); end
        total++; if (overrun_error !== 1'b1) begin bad++; $display("FAIL ovr_flag: got %0b want 1", overrun_error); end
        total++; if (line_error !== 1'b0) begin bad++; $display("FAIL ovr_line_error: got %0b want 0", line_error); end
        clear_pulse();
        total++; if (overrun_error !== 1'b0) begin bad++; $display("FAIL ovr_cleared: got %0b want 0", overrun_error); end
        hpulse();
        vpulse();
        clear_pulse();
    endtask

    task automatic test_coincidence();
        logic [13:0] a_last;
        logic [7:0]  d_last;
        mon_clear();
        for (int l = 0; l < 143; l++) begin
            send_pixels(160, 1'b1, 2'd0);
            hpulse();
        end
        send_pixels(159, 1'b1, 2'd0);
        pixel_latch = 1'b1; pixel_data = 2'd3; hsync = 1'b1; vsync = 1'b1;
        tick();
        pixel_latch = 1'b0; hsync = 1'b0; vsync = 1'b0;
        tick(); tick();
        a_last = (q_addr.size() > 0) ? q_addr[$] : 14'h0000;
        d_last = (q_data.size() > 0) ? q_data[$] : 8'h00;
        total++; if (wr_count !== 5760) begin bad++; $display("FAIL coin_wr_count: got %0d want 5760", wr_count); end
        total++; if (a_last !== 14'h367F || d_last !== 8'h1B) begin bad++; $display("FAIL coin_last_write: got %0h/%0h want 367f/1b", a_last, d_last); end
        total++; if (fd_count !== 1) begin bad++; $display("FAIL coin_frame_done: got %0d want 1", fd_count); end
        total++; if (front_bank !== 1'b1) begin bad++; $display("FAIL coin_front_bank: got %0b want 1", front_bank); end
        total++; if ({line_error, overrun_error, frame_error} !== 3'b000) begin bad++; $display("FAIL coin_errors: got %0b want 000", {line_error, overrun_error, frame_error}); end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_short_line();
        test_reset_mid_line();
        test_mid_enable();
        test_overrun();
        test_coincidence();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
